// File: rtl/serial_frame_rx_pkg.sv
// Shared types for the serial frame receiver: FSM state encoding and width default.
// The PARITY state only exists when SERIAL_FRAME_RX_PARITY_EN is defined.
package serial_frame_rx_pkg;

  localparam int DATA_W_DEFAULT = 8;

`ifdef SERIAL_FRAME_RX_PARITY_EN
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    PARITY = 2'd2,
    STOP   = 2'd3
  } state_t;
`else
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    STOP   = 2'd3
  } state_t;
`endif

endpackage

// File: rtl/sfrx_shift_in.sv
// Enable-gated serial-to-parallel shift register, LSB-first assembly.
// Latency: one bit per enabled clk; after DATA_W enables bit 0 holds the first bit.
// Backpressure: none; the owner gates en.
module sfrx_shift_in
  import serial_frame_rx_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEFAULT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              serial_in,
  output logic [DATA_W-1:0] data
);

  // New bits enter at the MSB so the earliest bit ends up in bit 0.
  always_ff @(posedge clk) begin
    if (rst) begin
      data <= '0;
    end else if (en) begin
      data <= {serial_in, data[DATA_W-1:1]};
    end
  end

endmodule

// File: rtl/serial_frame_rx.sv
// Serial frame receiver (start 1, DATA_W bits LSB first, [even parity], stop 0); parity via SERIAL_FRAME_RX_PARITY_EN.
// Latency: start bit -> out_valid is DATA_W+2 cycles (+1 with parity).
// Backpressure: one-word valid/ready buffer; a good frame arriving while the held word is unconsumed is dropped with an overrun pulse.
module serial_frame_rx
  import serial_frame_rx_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEFAULT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              serial_in,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  output logic              busy,
  output logic              frame_err,
  output logic              parity_err,
  output logic              overrun
);

  localparam int CNT_W = $clog2(DATA_W);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);

  state_t            state;
  logic [CNT_W-1:0]  bit_cnt;
  logic [DATA_W-1:0] shift_data;
  logic              shift_en;
  logic              frame_good;

  assign shift_en = (state == DATA);

  sfrx_shift_in #(
    .DATA_W(DATA_W)
  ) u_shift_in (
    .clk       (clk),
    .rst       (rst),
    .en        (shift_en),
    .serial_in (serial_in),
    .data      (shift_data)
  );

`ifdef SERIAL_FRAME_RX_PARITY_EN
  logic par_bad;
  logic parity_err_q;

  assign parity_err = parity_err_q;
  assign frame_good = (state == STOP) && !serial_in && !par_bad;
`else
  assign parity_err = 1'b0;
  assign frame_good = (state == STOP) && !serial_in;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      bit_cnt      <= '0;
      busy         <= 1'b0;
      frame_err    <= 1'b0;
      overrun      <= 1'b0;
      out_data     <= '0;
      out_valid    <= 1'b0;
`ifdef SERIAL_FRAME_RX_PARITY_EN
      par_bad      <= 1'b0;
      parity_err_q <= 1'b0;
`endif
    end else begin
      frame_err <= 1'b0;
      overrun   <= 1'b0;
`ifdef SERIAL_FRAME_RX_PARITY_EN
      parity_err_q <= 1'b0;
`endif

      case (state)
        IDLE: begin
          if (serial_in) begin
            state   <= DATA;
            bit_cnt <= '0;
            busy    <= 1'b1;
`ifdef SERIAL_FRAME_RX_PARITY_EN
            par_bad <= 1'b0;
`endif
          end
        end
        DATA: begin
          // Counter saturates at the last bit; it never wraps inside a frame.
          if (bit_cnt == LAST_BIT) begin
`ifdef SERIAL_FRAME_RX_PARITY_EN
            state <= PARITY;
`else
            state <= STOP;
`endif
          end else begin
            bit_cnt <= bit_cnt + 1'b1;
          end
        end
`ifdef SERIAL_FRAME_RX_PARITY_EN
        PARITY: begin
          // Even parity: data bits plus parity bit must hold an even number of ones.
          par_bad <= serial_in ^ (^shift_data);
          state   <= STOP;
        end
`endif
        STOP: begin
          state     <= IDLE;
          busy      <= 1'b0;
          frame_err <= serial_in;
`ifdef SERIAL_FRAME_RX_PARITY_EN
          parity_err_q <= par_bad;
`endif
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase

      // A consume and a new load in the same cycle keep out_valid high.
      if (frame_good) begin
        if (!out_valid || out_ready) begin
          out_data  <= shift_data;
          out_valid <= 1'b1;
        end else begin
          overrun <= 1'b1;
        end
      end else if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule
